spi_param_fifo: RTL

//  Parametrised synchronous FIFO for the SPI data path, next generation of the SPI TX/RX buffer.

---
 rtl/spi_param_fifo_pkg.sv | 33 +++
 rtl/spi_fifo_ram.sv | 38 +++
 rtl/spi_param_fifo.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/spi_param_fifo_pkg.sv
// ---------------------------------------------------------------------------
// spi_param_fifo_pkg
//   Shared definitions for the SPI TX/RX buffer family.
//   - SPI_FIFO_WIDTH / SPI_FIFO_DEPTH : default word width and entry count
//   - clog2()                          : elaboration-time ceil(log2) helper
//   - fifo_status_t                    : bundle of the decoded status bits
// ---------------------------------------------------------------------------
package spi_param_fifo_pkg;

  localparam int SPI_FIFO_WIDTH = 32;
  localparam int SPI_FIFO_DEPTH = 16;

  // ceil(log2(value)); returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_status_t;

endpackage

// File: rtl/spi_fifo_ram.sv
// ---------------------------------------------------------------------------
// spi_fifo_ram
//   DEPTH x WIDTH register array for the SPI FIFO. One synchronous write
//   port, one asynchronous read port. Contents are not reset.
//   Ports:
//     Clock    in   1      write clock (rising edge)
//     wr_en    in   1      write strobe
//     wr_addr  in   AW     write address
//     wr_data  in   WIDTH  write data
//     rd_addr  in   AW     read address
//     rd_data  out  WIDTH  combinational read data
// ---------------------------------------------------------------------------
module spi_fifo_ram
  import spi_param_fifo_pkg::*;
#(
  parameter int WIDTH = SPI_FIFO_WIDTH,
  parameter int DEPTH = SPI_FIFO_DEPTH,
  parameter int AW    = clog2(DEPTH)
) (
  input  logic             Clock,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge Clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/spi_param_fifo.sv
// ---------------------------------------------------------------------------
// spi_param_fifo
//   Parametrised synchronous first-word-fall-through FIFO for the SPI data
//   path. Holds the pointers, occupancy count, sticky error flags and status
//   decode; storage lives in spi_fifo_ram.
//   Ports:
//     Clock        in   1      single clock, rising edge
//     Reset_n      in   1      asynchronous active-low reset
//     Write        in   1      push request
//     DataIn       in   WIDTH  push data
//     Read         in   1      pop request
//     DataOut      out  WIDTH  head word, 0 while empty
//     Flush        in   1      synchronous empty request
//     ClearOV      in   1      clear overflow flag
//     ClearUF      in   1      clear underflow flag
//     Full         out  1      Level == DEPTH
//     Empty        out  1      Level == 0
//     AlmostFull   out  1      Level >= AF_LEVEL
//     AlmostEmpty  out  1      Level <= AE_LEVEL
//     Level        out  AW+1   occupancy 0..DEPTH
//     OV           out  1      sticky overflow
//     UF           out  1      sticky underflow
//
//   Handshake: Write/Read are requests sampled every rising edge. A push is
//   accepted when not full, or when full and a pop happens in the same cycle;
//   a pop is accepted when not empty. A rejected push drops its data and sets
//   OV, a rejected pop sets UF. Flush overrides both requests for that cycle
//   and sets no flag.
// ---------------------------------------------------------------------------
module spi_param_fifo
  import spi_param_fifo_pkg::*;
#(
  parameter int WIDTH    = SPI_FIFO_WIDTH,
  parameter int DEPTH    = SPI_FIFO_DEPTH,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int AW       = clog2(DEPTH)
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic             Write,
  input  logic [WIDTH-1:0] DataIn,
  input  logic             Read,
  output logic [WIDTH-1:0] DataOut,
  input  logic             Flush,
  input  logic             ClearOV,
  input  logic             ClearUF,
  output logic             Full,
  output logic             Empty,
  output logic             AlmostFull,
  output logic             AlmostEmpty,
  output logic [AW:0]      Level,
  output logic             OV,
  output logic             UF
);

  localparam logic [AW:0] LEVEL_FULL = (AW + 1)'(DEPTH);
  localparam logic [AW:0] LEVEL_AF   = (AW + 1)'(AF_LEVEL);
  localparam logic [AW:0] LEVEL_AE   = (AW + 1)'(AE_LEVEL);
  localparam logic [AW:0] LEVEL_ONE  = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      level;
  logic [AW:0]      level_nxt;
  logic             ov_q;
  logic             uf_q;
  logic             wr_ok;
  logic             rd_ok;
  logic             ov_set;
  logic             uf_set;
  logic [WIDTH-1:0] ram_rd_data;
  fifo_status_t     status;

  // Status decode: Level is the single source of truth for full/empty.
  always_comb begin
    status              = '0;
    status.full         = (level == LEVEL_FULL);
    status.empty        = (level == '0);
    status.almost_full  = (level >= LEVEL_AF);
    status.almost_empty = (level <= LEVEL_AE);
  end

  // Accept logic. A pop frees a slot in the same edge, so a full FIFO still
  // takes a push when it is popped at the same time.
  always_comb begin
    wr_ok  = Write & (~status.full | Read) & ~Flush;
    rd_ok  = Read & ~status.empty & ~Flush;
    ov_set = Write & status.full & ~Read & ~Flush;
    uf_set = Read & status.empty & ~Flush;
  end

  always_comb begin
    level_nxt = level;
    case ({wr_ok, rd_ok})
      2'b10:   level_nxt = level + LEVEL_ONE;
      2'b01:   level_nxt = level - LEVEL_ONE;
      default: level_nxt = level;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (Flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_ok) rd_ptr <= rd_ptr + PTR_ONE;
      level <= level_nxt;
    end
  end

  // Sticky flags: a set event in the same cycle as the clear wins.
  // Flush deliberately leaves the flags alone.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      ov_q <= 1'b0;
      uf_q <= 1'b0;
    end else begin
      if (ov_set)       ov_q <= 1'b1;
      else if (ClearOV) ov_q <= 1'b0;
      if (uf_set)       uf_q <= 1'b1;
      else if (ClearUF) uf_q <= 1'b0;
    end
  end

  spi_fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .Clock   (Clock),
    .wr_en   (wr_ok),
    .wr_addr (wr_ptr),
    .wr_data (DataIn),
    .rd_addr (rd_ptr),
    .rd_data (ram_rd_data)
  );

  // Mask the stale array word while empty so DataOut reads 0.
  assign DataOut     = status.empty ? '0 : ram_rd_data;
  assign Full        = status.full;
  assign Empty       = status.empty;
  assign AlmostFull  = status.almost_full;
  assign AlmostEmpty = status.almost_empty;
  assign Level       = level;
  assign OV          = ov_q;
  assign UF          = uf_q;

endmodule
